// File: rtl/regfile_arb_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package regfile_arb_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef enum logic {
        GRANT_S0 = 1'b0,
        GRANT_S1 = 1'b1
    } grant_t;

    typedef logic [AW_DEF-1:0] addr_t;
    typedef logic [DW_DEF-1:0] data_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback FIFO; full/empty come from the count, pointers wrap modulo DEPTH.
module wb_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [AW-1:0]               din_addr,
    input  logic [DW-1:0]               din_data,
    output logic [AW-1:0]               head_addr,
    output logic [DW-1:0]               head_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            ent_valid,
    output logic [DEPTH-1:0][AW-1:0]    ent_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [DEPTH-1:0][DW-1:0]   mem_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            // clear before set: a same-slot push/pop cannot happen, but push wins if it did
            if (pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                ent_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr            <= wr_ptr + 1'b1;
                ent_valid[wr_ptr] <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= din_addr;
            mem_data[wr_ptr] <= din_data;
        end
    end

    assign head_addr = ent_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter draining two writeback FIFOs onto the registered register-file
// write port, with pending-write hit flags for the three read addresses.
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s0_valid,
    output logic            s0_ready,
    input  logic [AW-1:0]   s0_addr,
    input  logic [DW-1:0]   s0_data,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  logic [AW-1:0]   s1_addr,
    input  logic [DW-1:0]   s1_data,
    output logic            we3,
    output logic [AW-1:0]   wa3,
    output logic [DW-1:0]   wd3,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic [AW-1:0]   ra3,
    output logic            hit1,
    output logic            hit2,
    output logic            hit3
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]              count0, count1;
    logic                       full0, full1, empty0, empty1;
    logic                       push0, push1, pop0, pop1;
    logic [AW-1:0]              head_addr0, head_addr1;
    logic [DW-1:0]              head_data0, head_data1;
    logic [DEPTH-1:0]           vld0, vld1;
    logic [DEPTH-1:0][AW-1:0]   ent0, ent1;

    grant_t         last_grant, gnt;
    logic           gnt_valid;
    logic [AW-1:0]  gnt_addr;
    logic [DW-1:0]  gnt_data;

    assign s0_ready = (count0 < FULL_CNT) && !reset;
    assign s1_ready = (count1 < FULL_CNT) && !reset;

    // writes to register 0 complete the handshake but never enter the queue
    assign push0 = s0_valid && s0_ready && !full0 && (s0_addr != '0);
    assign push1 = s1_valid && s1_ready && !full1 && (s1_addr != '0);

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo0 (
        .clk(clk), .reset(reset), .push(push0), .pop(pop0),
        .din_addr(s0_addr), .din_data(s0_data),
        .head_addr(head_addr0), .head_data(head_data0),
        .count(count0), .full(full0), .empty(empty0),
        .ent_valid(vld0), .ent_addr(ent0)
    );

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo1 (
        .clk(clk), .reset(reset), .push(push1), .pop(pop1),
        .din_addr(s1_addr), .din_data(s1_data),
        .head_addr(head_addr1), .head_data(head_data1),
        .count(count1), .full(full1), .empty(empty1),
        .ent_valid(vld1), .ent_addr(ent1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_S1;
            we3        <= 1'b0;
            wa3        <= '0;
            wd3        <= '0;
        end else begin
            we3 <= gnt_valid;
            if (gnt_valid) begin
                last_grant <= gnt;
                wa3        <= gnt_addr;
                wd3        <= gnt_data;
            end
        end
    end

    always_comb begin
        gnt       = GRANT_S0;
        gnt_valid = 1'b0;
        if (!empty0 && !empty1) begin
            gnt_valid = 1'b1;
            gnt       = (last_grant == GRANT_S1) ? GRANT_S0 : GRANT_S1;
        end else if (!empty0) begin
            gnt_valid = 1'b1;
            gnt       = GRANT_S0;
        end else if (!empty1) begin
            gnt_valid = 1'b1;
            gnt       = GRANT_S1;
        end
    end

    assign pop0     = gnt_valid && (gnt == GRANT_S0);
    assign pop1     = gnt_valid && (gnt == GRANT_S1);
    assign gnt_addr = (gnt == GRANT_S1) ? head_addr1 : head_addr0;
    assign gnt_data = (gnt == GRANT_S1) ? head_data1 : head_data0;

    logic [2:0][AW-1:0] ra_vec;
    logic [2:0]         hit_vec;

    assign ra_vec = {ra3, ra2, ra1};

    always_comb begin
        hit_vec = '0;
        for (int r = 0; r < 3; r++) begin
            if (we3 && (wa3 == ra_vec[r])) hit_vec[r] = 1'b1;
            for (int e = 0; e < DEPTH; e++) begin
                if (vld0[e] && (ent0[e] == ra_vec[r])) hit_vec[r] = 1'b1;
                if (vld1[e] && (ent1[e] == ra_vec[r])) hit_vec[r] = 1'b1;
            end
            if (ra_vec[r] == '0) hit_vec[r] = 1'b0;
        end
    end

    assign hit1 = hit_vec[0];
    assign hit2 = hit_vec[1];
    assign hit3 = hit_vec[2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter: reset, single write, contention, r0 discard,
// hazard flags, full FIFO back-pressure and async reset mid-stream.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           s0_valid = 1'b0, s1_valid = 1'b0;
    logic           s0_ready, s1_ready;
    logic [AW-1:0]  s0_addr = '0, s1_addr = '0;
    logic [DW-1:0]  s0_data = '0, s1_data = '0;
    logic           we3;
    logic [AW-1:0]  wa3;
    logic [DW-1:0]  wd3;
    logic [AW-1:0]  ra1 = '0, ra2 = '0, ra3 = '0;
    logic           hit1, hit2, hit3;

    int total = 0;
    int passed = 0;

    logic [AW-1:0]  src0_addr [8];
    logic [AW-1:0]  src1_addr [8];
    logic [AW-1:0]  exp_addr [8];
    logic [AW-1:0]  wr_addr [$];
    logic [DW-1:0]  wr_data [$];
    int             wr_cyc [$];
    logic           rdy0_log [40];
    logic           rdy1_log [40];

    regfile_wb_arbiter #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .ra3(ra3),
        .hit1(hit1), .hit2(hit2), .hit3(hit3)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        // sources tag their data so a crossed head/data pairing is visible
        return (a >= 5'd11 && a < 5'd21) || a >= 5'd31 ? (32'hB000_0000 | {27'd0, a})
                                                        : (32'hA000_0000 | {27'd0, a});
    endfunction

    task automatic apply_reset;
        reset = 1'b1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_streams(input int n0, input int n1);
        int  i0 = 0;
        int  i1 = 0;
        logic f0, f1;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        for (int c = 0; c < 30; c++) begin
            s0_valid = (i0 < n0);
            s0_addr  = (i0 < n0) ? src0_addr[i0] : '0;
            s0_data  = data_of(s0_addr);
            s1_valid = (i1 < n1);
            s1_addr  = (i1 < n1) ? src1_addr[i1] : '0;
            s1_data  = data_of(s1_addr);
            #1;
            rdy0_log[c] = s0_ready;
            rdy1_log[c] = s1_ready;
            f0 = s0_valid && s0_ready;
            f1 = s1_valid && s1_ready;
            @(posedge clk); #1;
            if (f0) i0++;
            if (f1) i1++;
            if (we3 === 1'b1) begin
                wr_addr.push_back(wa3);
                wr_data.push_back(wd3);
                wr_cyc.push_back(c + 1);
            end
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
    endtask

    task automatic test_reset;
        ra1 = 5'd1; ra2 = 5'd2; ra3 = 5'd3;
        s0_valid = 1'b1; s0_addr = 5'd9; s0_data = 32'h99;
        #1;
        total++; if (we3 !== 1'b0) $display("FAIL reset_we3: got %0b want 0", we3); else passed++;
        total++; if (wa3 !== '0) $display("FAIL reset_wa3: got %0d want 0", wa3); else passed++;
        total++; if (wd3 !== '0) $display("FAIL reset_wd3: got %h want 0", wd3); else passed++;
        total++; if (s0_ready !== 1'b0) $display("FAIL reset_s0_ready: got %0b want 0", s0_ready); else passed++;
        total++; if (s1_ready !== 1'b0) $display("FAIL reset_s1_ready: got %0b want 0", s1_ready); else passed++;
        @(posedge clk); #1;
        total++; if (we3 !== 1'b0) $display("FAIL reset_edge_we3: got %0b want 0", we3); else passed++;
        reset = 1'b0;
        s0_valid = 1'b0;
        #1;
        total++; if (s0_ready !== 1'b1) $display("FAIL release_s0_ready: got %0b want 1", s0_ready); else passed++;
        total++; if (s1_ready !== 1'b1) $display("FAIL release_s1_ready: got %0b want 1", s1_ready); else passed++;
        total++; if ({hit1, hit2, hit3} !== 3'b000) $display("FAIL reset_hits: got %b want 000", {hit1, hit2, hit3}); else passed++;
    endtask

    task automatic test_single;
        ra1 = '0; ra2 = '0; ra3 = '0;
        s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        s0_valid = 1'b0;
        total++; if (we3 !== 1'b0) $display("FAIL single_we3_early: got %0b want 0", we3); else passed++;
        @(posedge clk); #1;
        total++; if (we3 !== 1'b1) $display("FAIL single_we3: got %0b want 1", we3); else passed++;
        total++; if (wa3 !== 5'd5) $display("FAIL single_wa3: got %0d want 5", wa3); else passed++;
        total++; if (wd3 !== 32'hDEAD_BEEF) $display("FAIL single_wd3: got %h want deadbeef", wd3); else passed++;
        @(posedge clk); #1;
        total++; if (we3 !== 1'b0) $display("FAIL single_we3_after: got %0b want 0", we3); else passed++;
        total++; if (wa3 !== 5'd5) $display("FAIL single_wa3_hold: got %0d want 5", wa3); else passed++;
    endtask

    task automatic test_contention;
        logic [6:0] exp_r0;
        logic [6:0] exp_r1;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            src0_addr[i] = 5'(1 + i);
            src1_addr[i] = 5'(11 + i);
        end
        exp_addr[0] = 5'd1;  exp_addr[1] = 5'd11; exp_addr[2] = 5'd2; exp_addr[3] = 5'd12;
        exp_addr[4] = 5'd3;  exp_addr[5] = 5'd13; exp_addr[6] = 5'd4; exp_addr[7] = 5'd14;
        run_streams(4, 4);
        total++; if (wr_addr.size() != 8) $display("FAIL cont_count: got %0d writes want 8", wr_addr.size()); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= wr_addr.size() || wr_addr[i] !== exp_addr[i] || wr_data[i] !== data_of(exp_addr[i]))
                $display("FAIL cont_write%0d: got addr %0d data %h want addr %0d data %h", i,
                         (i < wr_addr.size()) ? wr_addr[i] : 5'd0, (i < wr_data.size()) ? wr_data[i] : 32'd0,
                         exp_addr[i], data_of(exp_addr[i]));
            else passed++;
        end
        total++;
        if (wr_cyc.size() != 8 || wr_cyc[7] - wr_cyc[0] != 7)
            $display("FAIL cont_no_idle: got span %0d want 7", (wr_cyc.size() == 8) ? wr_cyc[7] - wr_cyc[0] : -1);
        else passed++;
        exp_r0 = 7'b1010111;
        exp_r1 = 7'b0101011;
        for (int c = 0; c < 7; c++) begin
            total++;
            if (rdy0_log[c] !== exp_r0[c] || rdy1_log[c] !== exp_r1[c])
                $display("FAIL cont_ready_c%0d: got s0 %0b s1 %0b want s0 %0b s1 %0b", c,
                         rdy0_log[c], rdy1_log[c], exp_r0[c], exp_r1[c]);
            else passed++;
        end
    endtask

    task automatic test_reg0;
        ra1 = 5'd5; ra2 = 5'd9; ra3 = 5'd14;
        s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h1234;
        #1;
        total++; if (s1_ready !== 1'b1) $display("FAIL r0_ready_before: got %0b want 1", s1_ready); else passed++;
        @(posedge clk); #1;
        s1_valid = 1'b0;
        total++; if (s1_ready !== 1'b1) $display("FAIL r0_ready_after: got %0b want 1", s1_ready); else passed++;
        total++; if ({hit1, hit2, hit3} !== 3'b000) $display("FAIL r0_hits: got %b want 000", {hit1, hit2, hit3}); else passed++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if (we3 !== 1'b0) $display("FAIL r0_no_write_c%0d: got %0b want 0", c, we3); else passed++;
        end
    endtask

    task automatic test_hazard;
        ra1 = 5'd7; ra2 = 5'd0; ra3 = 5'd8;
        s1_valid = 1'b1; s1_addr = 5'd7; s1_data = 32'h77;
        #1;
        total++; if (hit1 !== 1'b0) $display("FAIL haz_hit1_before: got %0b want 0", hit1); else passed++;
        @(posedge clk); #1;
        s1_valid = 1'b0;
        total++; if ({hit1, hit2, hit3} !== 3'b100) $display("FAIL haz_queued: got %b want 100", {hit1, hit2, hit3}); else passed++;
        @(posedge clk); #1;
        total++; if (we3 !== 1'b1 || wa3 !== 5'd7) $display("FAIL haz_write: got we3 %0b wa3 %0d want 1 7", we3, wa3); else passed++;
        total++; if (hit1 !== 1'b1) $display("FAIL haz_hit1_inflight: got %0b want 1", hit1); else passed++;
        @(posedge clk); #1;
        total++; if (we3 !== 1'b0 || hit1 !== 1'b0) $display("FAIL haz_drop: got we3 %0b hit1 %0b want 0 0", we3, hit1); else passed++;
    endtask

    task automatic test_full;
        logic [4:0] exp_r0;
        apply_reset();
        ra1 = '0; ra2 = '0; ra3 = '0;
        src0_addr[0] = 5'd21; src0_addr[1] = 5'd22; src0_addr[2] = 5'd23; src0_addr[3] = 5'd24;
        src1_addr[0] = 5'd31; src1_addr[1] = 5'd1;  src1_addr[2] = 5'd2;
        exp_addr[0] = 5'd21; exp_addr[1] = 5'd31; exp_addr[2] = 5'd22; exp_addr[3] = 5'd1;
        exp_addr[4] = 5'd23; exp_addr[5] = 5'd2;  exp_addr[6] = 5'd24;
        run_streams(4, 3);
        total++; if (wr_addr.size() != 7) $display("FAIL full_count: got %0d writes want 7", wr_addr.size()); else passed++;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (i >= wr_addr.size() || wr_addr[i] !== exp_addr[i])
                $display("FAIL full_write%0d: got addr %0d want %0d", i,
                         (i < wr_addr.size()) ? wr_addr[i] : 5'd0, exp_addr[i]);
            else passed++;
        end
        exp_r0 = 5'b10111;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (rdy0_log[c] !== exp_r0[c])
                $display("FAIL full_s0_ready_c%0d: got %0b want %0b", c, rdy0_log[c], exp_r0[c]);
            else passed++;
        end
    endtask

    task automatic test_async_reset;
        apply_reset();
        s0_valid = 1'b1; s0_addr = 5'd1; s0_data = data_of(5'd1);
        s1_valid = 1'b1; s1_addr = 5'd11; s1_data = data_of(5'd11);
        @(posedge clk); #1;
        s0_addr = 5'd2; s0_data = data_of(5'd2);
        s1_addr = 5'd12; s1_data = data_of(5'd12);
        @(posedge clk); #1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        total++; if (we3 !== 1'b1 || wa3 !== 5'd1) $display("FAIL ar_inflight: got we3 %0b wa3 %0d want 1 1", we3, wa3); else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++; if (we3 !== 1'b0) $display("FAIL ar_we3: got %0b want 0", we3); else passed++;
        total++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) $display("FAIL ar_ready: got %0b%0b want 00", s0_ready, s1_ready); else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        ra1 = 5'd2; ra2 = 5'd12; ra3 = 5'd11;
        #1;
        total++; if ({hit1, hit2, hit3} !== 3'b000) $display("FAIL ar_hits: got %b want 000", {hit1, hit2, hit3}); else passed++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if (we3 !== 1'b0) $display("FAIL ar_stale_c%0d: got we3 %0b wa3 %0d want 0", c, we3, wa3); else passed++;
        end
        src0_addr[0] = 5'd3;
        src1_addr[0] = 5'd13;
        run_streams(1, 1);
        total++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 5'd3 || wr_addr[1] !== 5'd13)
            $display("FAIL ar_first_grant: got %0d writes first %0d want 2 writes 3 then 13",
                     wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 5'd0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_reg0();
        test_hazard();
        test_full();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
